// File: rtl/lbist_pkg.sv
// Shared types and default constants for the logic BIST controller.
package lbist_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StShift,
    StCapture,
    StUnload,
    StCompare,
    StDone
  } lbist_state_e;

  localparam logic [31:0] LBIST_LFSR_POLY_DEF = 32'h8020_0003;
  localparam logic [31:0] LBIST_MISR_POLY_DEF = 32'h04C1_1DB7;
  localparam logic [31:0] LBIST_SEED_DEF      = 32'h0000_0001;

endpackage

// File: rtl/lbist_misr.sv
// Multiple-input signature register: shift-left Galois compaction of data_i.
module lbist_misr
  import lbist_pkg::*;
#(
  parameter int unsigned      WIDTH = 32,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(LBIST_MISR_POLY_DEF)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] sig_o
);

  logic [WIDTH-1:0] r_sig;
  logic [WIDTH-1:0] w_sig_next;

  always_comb begin
    w_sig_next = {r_sig[WIDTH-2:0], 1'b0} ^ (r_sig[WIDTH-1] ? POLY : '0) ^ data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig <= '0;
    end else if (clear) begin
      r_sig <= '0;
    end else if (enable) begin
      r_sig <= w_sig_next;
    end
  end

  assign sig_o = r_sig;

endmodule

// File: rtl/lbist_ctrl.sv
// Logic BIST controller: LFSR pattern source, scan sequencing FSM and MISR check.
// Optional LBIST_SIG_OUT_EN exposes the final signature on misr_sig_o.
module lbist_ctrl
  import lbist_pkg::*;
#(
  parameter int unsigned           PATTERN_COUNT = 1024,
  parameter int unsigned           CHAIN_LEN     = 64,
  parameter int unsigned           SCAN_CHAINS   = 8,
  parameter int unsigned           LFSR_WIDTH    = 32,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY     = LFSR_WIDTH'(LBIST_LFSR_POLY_DEF),
  parameter logic [LFSR_WIDTH-1:0] LFSR_SEED     = LFSR_WIDTH'(LBIST_SEED_DEF),
  parameter int unsigned           MISR_WIDTH    = 32,
  parameter logic [MISR_WIDTH-1:0] MISR_POLY     = MISR_WIDTH'(LBIST_MISR_POLY_DEF),
  parameter logic [MISR_WIDTH-1:0] GOLDEN_SIG    = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   test_en,
  output logic                   scan_en_o,
  output logic [SCAN_CHAINS-1:0] scan_in_o,
  input  logic [SCAN_CHAINS-1:0] scan_out_i,
  output logic                   bist_end,
  output logic                   bist_go
`ifdef LBIST_SIG_OUT_EN
  ,
  output logic [MISR_WIDTH-1:0]  misr_sig_o
`endif
);

  localparam int unsigned SW = $clog2(CHAIN_LEN + 1);
  localparam int unsigned PW = $clog2(PATTERN_COUNT + 1);
  localparam logic [SW-1:0] ShiftLast = SW'(CHAIN_LEN - 1);
  localparam logic [PW-1:0] PatLast   = PW'(PATTERN_COUNT);

  lbist_state_e          r_state;
  logic [LFSR_WIDTH-1:0] r_lfsr;
  logic [SW-1:0]         r_shift_cnt;
  logic [PW-1:0]         r_pat_cnt;
  logic                  r_scan_en;
  logic                  r_bist_end;
  logic                  r_bist_go;

  logic [LFSR_WIDTH-1:0] w_lfsr_next;
  logic [PW-1:0]         w_pat_inc;
  logic [MISR_WIDTH-1:0] w_misr_data;
  logic [MISR_WIDTH-1:0] w_misr_sig;
  logic                  w_misr_en;
  logic                  w_misr_clr;

  always_comb begin
    w_lfsr_next = {r_lfsr[LFSR_WIDTH-2:0], ^(r_lfsr & LFSR_POLY)};
    w_pat_inc   = r_pat_cnt + PW'(1);
    w_misr_data = '0;
    w_misr_data[SCAN_CHAINS-1:0] = scan_out_i;
    // Pattern 0 unloads reset content of the chains, so it is kept out of the signature.
    w_misr_en  = ((r_state == StShift) && (r_pat_cnt != '0)) || (r_state == StUnload);
    w_misr_clr = (r_state == StIdle) || !test_en;
  end

  lbist_misr #(
    .WIDTH (MISR_WIDTH),
    .POLY  (MISR_POLY)
  ) u_misr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (w_misr_clr),
    .enable (w_misr_en),
    .data_i (w_misr_data),
    .sig_o  (w_misr_sig)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_lfsr      <= LFSR_SEED;
      r_shift_cnt <= '0;
      r_pat_cnt   <= '0;
      r_scan_en   <= 1'b0;
      r_bist_end  <= 1'b0;
      r_bist_go   <= 1'b0;
    end else if (!test_en) begin
      r_state     <= StIdle;
      r_lfsr      <= LFSR_SEED;
      r_shift_cnt <= '0;
      r_pat_cnt   <= '0;
      r_scan_en   <= 1'b0;
      r_bist_end  <= 1'b0;
      r_bist_go   <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_state   <= StShift;
          r_scan_en <= 1'b1;
        end
        StShift: begin
          r_lfsr <= w_lfsr_next;
          if (r_shift_cnt == ShiftLast) begin
            r_shift_cnt <= '0;
            r_scan_en   <= 1'b0;
            r_state     <= StCapture;
          end else begin
            r_shift_cnt <= r_shift_cnt + SW'(1);
          end
        end
        StCapture: begin
          r_pat_cnt <= w_pat_inc;
          r_scan_en <= 1'b1;
          r_state   <= (w_pat_inc == PatLast) ? StUnload : StShift;
        end
        StUnload: begin
          if (r_shift_cnt == ShiftLast) begin
            r_shift_cnt <= '0;
            r_scan_en   <= 1'b0;
            r_state     <= StCompare;
          end else begin
            r_shift_cnt <= r_shift_cnt + SW'(1);
          end
        end
        StCompare: begin
          r_bist_end <= 1'b1;
          r_bist_go  <= (w_misr_sig == GOLDEN_SIG);
          r_state    <= StDone;
        end
        StDone: begin
          r_state <= StDone;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign scan_en_o = r_scan_en;
  assign scan_in_o = r_lfsr[SCAN_CHAINS-1:0];
  assign bist_end  = r_bist_end;
  assign bist_go   = r_bist_go;

`ifdef LBIST_SIG_OUT_EN
  logic [MISR_WIDTH-1:0] r_sig_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig_out <= '0;
    end else if (!test_en || (r_state == StIdle)) begin
      r_sig_out <= '0;
    end else if (r_state == StCompare) begin
      r_sig_out <= w_misr_sig;
    end
  end

  assign misr_sig_o = r_sig_out;
`endif

endmodule
